// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared definitions for the fetch/execute control slice of the two-stage
//   RISC-V core: sequencer state encoding, PC step size and a helper that
//   forces a redirect target onto a word boundary.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    SEQ_RUN   = 2'd0,
    SEQ_STALL = 2'd1,
    SEQ_HALT  = 2'd2,
    SEQ_FAULT = 2'd3
  } seq_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Instructions are word aligned; the low two target bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/mc_watchdog.sv
// mc_watchdog
//   Counts cycles spent waiting on the multi-cycle execute unit and flags
//   the last permitted wait cycle.
// Ports:
//   clk     in   core clock
//   res     in   asynchronous active-low reset
//   clear   in   restart the count at zero (new multi-cycle op)
//   en      in   one more wait cycle has elapsed without a result
//   expire  out  the current wait cycle is the last one allowed
// TIMEOUT = 0 turns the watchdog off: expire is then constant 0.
module mc_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic res,
  input  logic clear,
  input  logic en,
  output logic expire
);

  // Width is $clog2(TIMEOUT+1); keep at least one bit so the disabled
  // configuration still elaborates.
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch/execute sequencer: owns the program counter, the instruction
//   register load enable and the liveness of the EX-stage instruction.
//   Redirects on taken branches/jumps (squashing the wrong-path fetch),
//   stalls around the multi-cycle unit with a watchdog, and handles
//   EBREAK halt/resume.
// Ports:
//   clk, res        clock, asynchronous active-low reset
//   ex_halt         EX instruction is EBREAK
//   ex_redirect     EX instruction is a taken branch/JAL/JALR
//   ex_target       redirect target (bits [1:0] ignored)
//   ex_multicycle   EX instruction needs the multi-cycle unit
//   mc_done         multi-cycle result valid (one-cycle pulse)
//   resume          leave HALT
//   pc_F            instruction memory fetch address
//   pc_EX           PC of the instruction in EX
//   ir_load         IR and pc_EX load enable
//   ex_valid        EX instruction is architecturally live
//   ex_commit       EX instruction writes back this cycle
//   mc_start        start pulse to the multi-cycle unit
//   halted          in HALT or FAULT
//   fault           watchdog expired
//   dbg_state       current sequencer state
//
// Multi-cycle handshake: mc_start is a single-cycle pulse issued in the RUN
// cycle that dispatches the op; the unit answers with a single-cycle mc_done
// pulse some cycles later, and the sequencer accepts it in the same cycle it
// arrives (that cycle commits). mc_done outside STALL is ignored, and
// mc_start is never raised while waiting.
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        res,
  input  logic        ex_halt,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        ex_multicycle,
  input  logic        mc_done,
  input  logic        resume,
  output logic [31:0] pc_F,
  output logic [31:0] pc_EX,
  output logic        ir_load,
  output logic        ex_valid,
  output logic        ex_commit,
  output logic        mc_start,
  output logic        halted,
  output logic        fault,
  output seq_state_t  dbg_state
);

  seq_state_t  state;
  seq_state_t  state_nxt;
  logic [31:0] pc_f_nxt;
  logic        valid_nxt;
  logic        wd_clear;
  logic        wd_en;
  logic        wd_expire;

  mc_watchdog #(
    .TIMEOUT (MC_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .res    (res),
    .clear  (wd_clear),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= SEQ_RUN;
      pc_F     <= RESET_PC;
      pc_EX    <= RESET_PC;
      ex_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_F     <= pc_f_nxt;
      ex_valid <= valid_nxt;
      // pc_EX tracks the address of whatever word the IR captures.
      if (ir_load) begin
        pc_EX <= pc_F;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_f_nxt  = pc_F;
    valid_nxt = ex_valid;
    ir_load   = 1'b0;
    ex_commit = 1'b0;
    mc_start  = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    wd_clear  = 1'b0;
    wd_en     = 1'b0;

    case (state)
      SEQ_RUN: begin
        if (!ex_valid) begin
          // Bubble (after reset, redirect or resume): fetch only.
          ir_load   = 1'b1;
          pc_f_nxt  = pc_F + PC_STEP;
          valid_nxt = 1'b1;
        end else if (ex_halt) begin
          valid_nxt = 1'b0;
          state_nxt = SEQ_HALT;
        end else if (ex_redirect) begin
          // Commit the link write; the word fetched alongside is wrong-path.
          ex_commit = 1'b1;
          ir_load   = 1'b1;
          pc_f_nxt  = word_align(ex_target);
          valid_nxt = 1'b0;
        end else if (ex_multicycle) begin
          mc_start  = 1'b1;
          wd_clear  = 1'b1;
          state_nxt = SEQ_STALL;
        end else begin
          ex_commit = 1'b1;
          ir_load   = 1'b1;
          pc_f_nxt  = pc_F + PC_STEP;
        end
      end

      SEQ_STALL: begin
        if (mc_done) begin
          // A result in the last permitted cycle beats the watchdog.
          ex_commit = 1'b1;
          ir_load   = 1'b1;
          pc_f_nxt  = pc_F + PC_STEP;
          state_nxt = SEQ_RUN;
        end else begin
          wd_en = 1'b1;
          if (wd_expire) begin
            valid_nxt = 1'b0;
            state_nxt = SEQ_FAULT;
          end
        end
      end

      SEQ_HALT: begin
        halted    = 1'b1;
        valid_nxt = 1'b0;
        if (resume) begin
          state_nxt = SEQ_RUN;
        end
      end

      SEQ_FAULT: begin
        halted    = 1'b1;
        fault     = 1'b1;
        valid_nxt = 1'b0;
      end

      default: begin
        state_nxt = SEQ_RUN;
      end
    endcase
  end

  assign dbg_state = state;

endmodule
